riscv_core_vec_lsu: RTL

Vector load/store sequencer for the riscvvec datapath. It is the memory end of the 256-bit vector register path. For a vector load it issues up to 8 strided 32-bit memory reads and packs the responses into a 256-bit vector result for writeback. For a vector store it unpacks a 256-bit vector into up to 8 strided 32-bit memory writes. It sits between the vector register read/writeback ports and the core data-memory val/rdy interface.

---
 rtl/riscv_core_vec_lsu_if.sv | 50 +++++
 rtl/riscv_core_vec_lsu.sv | 134 +++++++++++++
 2 files changed

// File: rtl/riscv_core_vec_lsu_if.sv
// Handshake bundle between the vector LSU, the vector register ports and data memory.
// The slave view belongs to the LSU; the master view belongs to whatever drives it.
interface riscv_core_vec_lsu_if #(
  parameter int NLANES = 8,
  parameter int ELEM_W = 32
);
  logic                     cmd_val;
  logic                     cmd_rdy;
  logic                     cmd_store;
  logic [31:0]              cmd_base;
  logic [31:0]              cmd_stride;
  logic [3:0]               cmd_vl;
  logic [NLANES*ELEM_W-1:0] cmd_vdata;

  logic                     memreq_val;
  logic                     memreq_rdy;
  logic                     memreq_rw;
  logic [31:0]              memreq_addr;
  logic [ELEM_W-1:0]        memreq_data;

  logic                     memresp_val;
  logic                     memresp_rdy;
  logic [ELEM_W-1:0]        memresp_data;

  logic                     done_val;
  logic                     done_rdy;
  logic [NLANES*ELEM_W-1:0] done_vdata;

  modport master (
    output cmd_val, cmd_store, cmd_base, cmd_stride, cmd_vl, cmd_vdata,
    input  cmd_rdy,
    input  memreq_val, memreq_rw, memreq_addr, memreq_data,
    output memreq_rdy,
    output memresp_val, memresp_data,
    input  memresp_rdy,
    input  done_val, done_vdata,
    output done_rdy
  );

  modport slave (
    input  cmd_val, cmd_store, cmd_base, cmd_stride, cmd_vl, cmd_vdata,
    output cmd_rdy,
    output memreq_val, memreq_rw, memreq_addr, memreq_data,
    input  memreq_rdy,
    input  memresp_val, memresp_data,
    output memresp_rdy,
    output done_val, done_vdata,
    input  done_rdy
  );
endinterface

// File: rtl/riscv_core_vec_lsu.sv
// Vector load/store sequencer: turns one 256-bit vector command into up to NLANES
// strided 32-bit memory accesses, packing load responses into a writeback vector.
module riscv_core_vec_lsu #(
  parameter int NLANES = 8,
  parameter int ELEM_W = 32
) (
  input logic                clk,
  input logic                reset,
  riscv_core_vec_lsu_if.slave bus
);
  localparam int VL_W  = 4;
  localparam int IDX_W = $clog2(NLANES);
  localparam int VEC_W = NLANES * ELEM_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic              store_reg, store_next;
  logic [31:0]       base_reg, base_next;
  logic [31:0]       stride_reg, stride_next;
  logic [VL_W-1:0]   vl_reg, vl_next;
  logic [VL_W-1:0]   req_idx_reg, req_idx_next;
  logic [VL_W-1:0]   resp_idx_reg, resp_idx_next;
  logic [VEC_W-1:0]  vdata_reg, vdata_next;

  logic              cmd_fire;
  logic              req_fire;
  logic              resp_fire;
  logic              done_fire;
  logic              req_pending;
  logic [VL_W-1:0]   cmd_vl_clamped;
  logic [IDX_W-1:0]  lane_sel;
  logic [31:0]       req_offset;

  assign cmd_vl_clamped = (bus.cmd_vl > VL_W'(NLANES)) ? VL_W'(NLANES) : bus.cmd_vl;
  assign req_pending    = (state_reg == BUSY) && (req_idx_reg < vl_reg);
  assign lane_sel       = req_idx_reg[IDX_W-1:0];
  // Multiply is truncated to 32 bits so negative strides wrap naturally.
  assign req_offset     = 32'(req_idx_reg) * stride_reg;

  assign cmd_fire  = bus.cmd_val && (state_reg == IDLE);
  assign req_fire  = req_pending && bus.memreq_rdy;
  assign resp_fire = bus.memresp_val && (state_reg == BUSY);
  assign done_fire = bus.done_rdy && (state_reg == DONE);

  assign bus.cmd_rdy     = (state_reg == IDLE);
  assign bus.memreq_val  = req_pending;
  assign bus.memreq_rw   = req_pending && store_reg;
  assign bus.memreq_addr = req_pending ? (base_reg + req_offset) : 32'h0;
  assign bus.memreq_data = (req_pending && store_reg)
                           ? vdata_reg[32'(lane_sel) * ELEM_W +: ELEM_W] : '0;
  assign bus.memresp_rdy = (state_reg == BUSY);
  assign bus.done_val    = (state_reg == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      store_reg    <= 1'b0;
      base_reg     <= '0;
      stride_reg   <= '0;
      vl_reg       <= '0;
      req_idx_reg  <= '0;
      resp_idx_reg <= '0;
      vdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      store_reg    <= store_next;
      base_reg     <= base_next;
      stride_reg   <= stride_next;
      vl_reg       <= vl_next;
      req_idx_reg  <= req_idx_next;
      resp_idx_reg <= resp_idx_next;
      vdata_reg    <= vdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    store_next    = store_reg;
    base_next     = base_reg;
    stride_next   = stride_reg;
    vl_next       = vl_reg;
    req_idx_next  = req_idx_reg;
    resp_idx_next = resp_idx_reg;
    vdata_next    = vdata_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          store_next    = bus.cmd_store;
          base_next     = bus.cmd_base;
          stride_next   = bus.cmd_stride;
          vl_next       = cmd_vl_clamped;
          vdata_next    = bus.cmd_vdata;
          req_idx_next  = '0;
          resp_idx_next = '0;
          state_next    = (cmd_vl_clamped == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (req_fire) begin
          req_idx_next = req_idx_reg + VL_W'(1);
        end
        // Requests and responses advance independently; the last response ends the op.
        if (resp_fire) begin
          resp_idx_next = resp_idx_reg + VL_W'(1);
          if (resp_idx_reg == vl_reg - VL_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (done_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Each lane owns its slice of the result; cleared on accept so unused lanes read 0.
  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    logic [ELEM_W-1:0] lane_reg;

    always_ff @(posedge clk) begin
      if (reset || cmd_fire) begin
        lane_reg <= '0;
      end else if (resp_fire && !store_reg && (resp_idx_reg == VL_W'(gi))) begin
        lane_reg <= bus.memresp_data;
      end
    end

    assign bus.done_vdata[gi*ELEM_W +: ELEM_W] = (state_reg == DONE) ? lane_reg : '0;
  end
endmodule
